// File: rtl/phase2speed_mc.sv
// phase2speed_mc: multi-channel phase-difference to speed converter.
// Channels share one 3-stage pipeline and are told apart by a channel tag:
// S1 scales the phase, S2 rounds/shifts and saturates, S3 runs a per-channel
// 2^LOG2_N moving average and registers the outputs.
module phase2speed_mc #(
    parameter int CHANNELS = 2,
    parameter int IN_W     = 19,
    parameter int OUT_W    = 16,
    parameter int K_W      = 18,
    parameter int K_SCALE  = 1,
    parameter int SHIFT    = 0,
    parameter int LOG2_N   = 3,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sample,
    input  logic [CW-1:0]           chan,
    input  logic signed [IN_W-1:0]  phase,
    input  logic                    flush,
    output logic signed [OUT_W-1:0] speed,
    output logic [CW-1:0]           speed_chan,
    output logic                    ready,
    output logic                    settled,
    output logic                    sat,
    output logic                    chan_err
);

    localparam int P_W   = IN_W + K_W;
    localparam int SUM_W = OUT_W + LOG2_N;
    localparam int DEPTH = 1 << LOG2_N;
    localparam int PW    = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int FW    = LOG2_N + 1;

    localparam logic signed [K_W-1:0] K_VAL   = K_W'(K_SCALE);
    localparam logic signed [P_W-1:0] HALF    = P_W'((2 ** SHIFT) / 2);
    localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] SAT_MIN = {{(P_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [CW:0]           CH_LIM  = (CW+1)'(CHANNELS);
    localparam logic [FW-1:0]         FULL    = FW'(DEPTH);

    // Round half up, then arithmetic shift right; HALF is zero when SHIFT is 0.
    function automatic logic signed [P_W-1:0] round_shift(input logic signed [P_W-1:0] p);
        logic signed [P_W-1:0] biased;
        biased = p + HALF;
        return biased >>> SHIFT;
    endfunction

    // Clip to the OUT_W range; the MSB of the result flags that clipping happened.
    function automatic logic [OUT_W:0] saturate(input logic signed [P_W-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic                    chan_ok;
    logic signed [P_W-1:0]   phase_ext;
    logic signed [P_W-1:0]   k_ext;
    logic signed [P_W-1:0]   prod_p0;
    logic [CW-1:0]           chan_p0;
    logic                    vld_p0;

    logic [OUT_W:0]          sat_res;
    logic signed [OUT_W-1:0] q_p1;
    logic                    sat_p1;
    logic [CW-1:0]           chan_p1;
    logic                    vld_p1;

    logic signed [SUM_W-1:0] sum_r  [CHANNELS];
    logic signed [OUT_W-1:0] hist_r [CHANNELS][DEPTH];
    logic [PW-1:0]           wp_r   [CHANNELS];
    logic [FW-1:0]           fill_r [CHANNELS];

    logic signed [OUT_W-1:0] oldest;
    logic signed [SUM_W-1:0] sum_nxt;
    logic [FW-1:0]           fill_nxt;
    logic [PW-1:0]           wp_nxt;

    assign chan_ok   = ({1'b0, chan} < CH_LIM);
    assign phase_ext = P_W'(phase);
    assign k_ext     = P_W'(K_VAL);

    // ---- S1: full-precision scale; out-of-range tags are dropped here ----
    // Capture the product and flag bad channel tags one cycle after the strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p0   <= 1'b0;
            chan_err <= 1'b0;
            chan_p0  <= '0;
            prod_p0  <= '0;
        end else begin
            vld_p0   <= sample && chan_ok;
            chan_err <= sample && !chan_ok;
            chan_p0  <= chan;
            prod_p0  <= phase_ext * k_ext;
        end
    end

    // ---- S2: round, shift and saturate to OUT_W ----
    assign sat_res = saturate(round_shift(prod_p0));

    // Register the clipped sample and its clip flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            chan_p1 <= '0;
            q_p1    <= '0;
            sat_p1  <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            chan_p1 <= chan_p0;
            q_p1    <= sat_res[OUT_W-1:0];
            sat_p1  <= sat_res[OUT_W];
        end
    end

    // ---- S3: per-channel moving average ----
    // Read-modify-write of the channel state completes in this one cycle, so a
    // sample on the same channel next cycle already sees the updated sum/history.
    always_comb begin
        oldest   = hist_r[chan_p1][wp_r[chan_p1]];
        sum_nxt  = sum_r[chan_p1] + SUM_W'(q_p1) - SUM_W'(oldest);
        fill_nxt = (fill_r[chan_p1] == FULL) ? FULL : fill_r[chan_p1] + 1'b1;
        wp_nxt   = (DEPTH == 1) ? '0 : wp_r[chan_p1] + 1'b1;
    end

    // Update the channel state (flush clears every channel) and register outputs.
    // A sample finishing S3 on the flush edge still reports its result, but its
    // state update is discarded along with the rest of the history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sum_r[c]  <= '0;
                wp_r[c]   <= '0;
                fill_r[c] <= '0;
                for (int d = 0; d < DEPTH; d++) hist_r[c][d] <= '0;
            end
            ready      <= 1'b0;
            speed      <= '0;
            speed_chan <= '0;
            settled    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            ready <= vld_p1;
            if (vld_p1) begin
                speed      <= OUT_W'(sum_nxt >>> LOG2_N);
                speed_chan <= chan_p1;
                settled    <= (fill_nxt == FULL);
                sat        <= sat_p1;
            end
            if (flush) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    sum_r[c]  <= '0;
                    wp_r[c]   <= '0;
                    fill_r[c] <= '0;
                    for (int d = 0; d < DEPTH; d++) hist_r[c][d] <= '0;
                end
            end else if (vld_p1) begin
                sum_r[chan_p1]                <= sum_nxt;
                hist_r[chan_p1][wp_r[chan_p1]] <= q_p1;
                wp_r[chan_p1]                 <= wp_nxt;
                fill_r[chan_p1]               <= fill_nxt;
            end
        end
    end

endmodule

// File: tb/tb_phase2speed_mc.sv
// Testbench for phase2speed_mc: one averaging instance (3 channels, K=1,
// N=4) and one scaling instance (2 channels, K=3000, SHIFT=2, no averaging).
module tb_phase2speed_mc;

    localparam int MAXL = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic               sample_a = 1'b0;
    logic [1:0]         chan_a   = '0;
    logic signed [18:0] phase_a  = '0;
    logic               flush_a  = 1'b0;
    logic signed [15:0] speed_a;
    logic [1:0]         speed_chan_a;
    logic               ready_a, settled_a, sat_a, chan_err_a;

    logic               sample_b = 1'b0;
    logic [0:0]         chan_b   = '0;
    logic signed [18:0] phase_b  = '0;
    logic               flush_b  = 1'b0;
    logic signed [15:0] speed_b;
    logic [0:0]         speed_chan_b;
    logic               ready_b, settled_b, sat_b, chan_err_b;

    phase2speed_mc #(.CHANNELS(3), .IN_W(19), .OUT_W(16), .K_W(18),
                     .K_SCALE(1), .SHIFT(0), .LOG2_N(2)) dut_a (
        .clock(clock), .reset(reset), .sample(sample_a), .chan(chan_a),
        .phase(phase_a), .flush(flush_a), .speed(speed_a),
        .speed_chan(speed_chan_a), .ready(ready_a), .settled(settled_a),
        .sat(sat_a), .chan_err(chan_err_a));

    phase2speed_mc #(.CHANNELS(2), .IN_W(19), .OUT_W(16), .K_W(18),
                     .K_SCALE(3000), .SHIFT(2), .LOG2_N(0)) dut_b (
        .clock(clock), .reset(reset), .sample(sample_b), .chan(chan_b),
        .phase(phase_b), .flush(flush_b), .speed(speed_b),
        .speed_chan(speed_chan_b), .ready(ready_b), .settled(settled_b),
        .sat(sat_b), .chan_err(chan_err_b));

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus per cycle and expected result per stimulus slot
    bit sa_v[MAXL]; int sa_ch[MAXL]; int sa_ph[MAXL]; bit sa_fl[MAXL];
    bit sb_v[MAXL]; int sb_ch[MAXL]; int sb_ph[MAXL];
    int ea_sp[MAXL]; bit ea_set[MAXL]; bit ea_sat[MAXL];
    int eb_sp[MAXL]; bit eb_sat[MAXL];

    // observed outputs per cycle
    logic oa_rdy[MAXL]; logic oa_set[MAXL]; logic oa_sat[MAXL]; logic oa_err[MAXL];
    int   oa_sp[MAXL];  int   oa_ch[MAXL];
    logic ob_rdy[MAXL]; logic ob_set[MAXL]; logic ob_sat[MAXL]; logic ob_err[MAXL];
    int   ob_sp[MAXL];  int   ob_ch[MAXL];

    // reference model state: sliding window of the last 4 scaled samples per channel
    longint win_a[3][4];
    int     cnt_a[3];

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic longint scale_q(input longint ph, input longint k, input int sh, output bit s);
        longint p, q;
        p = ph * k;
        if (sh > 0) q = fdiv(p + (longint'(1) << (sh - 1)), longint'(1) << sh);
        else        q = p;
        s = 1'b0;
        if (q > 32767)       begin q = 32767;  s = 1'b1; end
        else if (q < -32768) begin q = -32768; s = 1'b1; end
        return q;
    endfunction

    task automatic model_a(input int ch, input int ph, output int sp, output bit st, output bit sv);
        longint q, s;
        bit sf;
        q = scale_q(ph, 1, 0, sf);
        for (int i = 0; i < 3; i++) win_a[ch][i] = win_a[ch][i+1];
        win_a[ch][3] = q;
        if (cnt_a[ch] < 4) cnt_a[ch]++;
        s = 0;
        for (int i = 0; i < 4; i++) s += win_a[ch][i];
        sp = int'(fdiv(s, 4));
        st = (cnt_a[ch] == 4);
        sv = sf;
    endtask

    task automatic clear_all();
        for (int k = 0; k < MAXL; k++) begin
            sa_v[k] = 0; sa_ch[k] = 0; sa_ph[k] = 0; sa_fl[k] = 0;
            sb_v[k] = 0; sb_ch[k] = 0; sb_ph[k] = 0;
            ea_sp[k] = 0; ea_set[k] = 0; ea_sat[k] = 0;
            eb_sp[k] = 0; eb_sat[k] = 0;
        end
        for (int c = 0; c < 3; c++) begin
            cnt_a[c] = 0;
            for (int i = 0; i < 4; i++) win_a[c][i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        sample_a = 0; flush_a = 0; sample_b = 0; flush_b = 0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        clear_all();
    endtask

    // Drive len cycles of stimulus (then 4 idle) and record outputs each negedge.
    task automatic run_cycles(input int len);
        for (int k = 0; k < len + 4; k++) begin
            @(negedge clock);
            oa_rdy[k] = ready_a; oa_set[k] = settled_a; oa_sat[k] = sat_a; oa_err[k] = chan_err_a;
            oa_sp[k] = int'(speed_a); oa_ch[k] = int'(speed_chan_a);
            ob_rdy[k] = ready_b; ob_set[k] = settled_b; ob_sat[k] = sat_b; ob_err[k] = chan_err_b;
            ob_sp[k] = int'(speed_b); ob_ch[k] = int'(speed_chan_b);
            if (k < len) begin
                sample_a = sa_v[k]; chan_a = 2'(sa_ch[k]); phase_a = 19'(sa_ph[k]); flush_a = sa_fl[k];
                sample_b = sb_v[k]; chan_b = 1'(sb_ch[k]); phase_b = 19'(sb_ph[k]);
            end else begin
                sample_a = 0; flush_a = 0; sample_b = 0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++; if (speed_a !== 16'sd0)     begin n_fail++; $display("FAIL reset_speed_a got %0d want 0", speed_a); end
        n_checks++; if (speed_chan_a !== 2'd0)  begin n_fail++; $display("FAIL reset_chan_a got %0d want 0", speed_chan_a); end
        n_checks++; if (ready_a !== 1'b0)       begin n_fail++; $display("FAIL reset_ready_a got %b want 0", ready_a); end
        n_checks++; if (settled_a !== 1'b0)     begin n_fail++; $display("FAIL reset_settled_a got %b want 0", settled_a); end
        n_checks++; if (sat_a !== 1'b0)         begin n_fail++; $display("FAIL reset_sat_a got %b want 0", sat_a); end
        n_checks++; if (chan_err_a !== 1'b0)    begin n_fail++; $display("FAIL reset_chan_err_a got %b want 0", chan_err_a); end
        n_checks++; if (speed_b !== 16'sd0)     begin n_fail++; $display("FAIL reset_speed_b got %0d want 0", speed_b); end
        n_checks++; if (speed_chan_b !== 1'b0)  begin n_fail++; $display("FAIL reset_chan_b got %0d want 0", speed_chan_b); end
        n_checks++; if (ready_b !== 1'b0)       begin n_fail++; $display("FAIL reset_ready_b got %b want 0", ready_b); end
        n_checks++; if (settled_b !== 1'b0)     begin n_fail++; $display("FAIL reset_settled_b got %b want 0", settled_b); end
        n_checks++; if (sat_b !== 1'b0)         begin n_fail++; $display("FAIL reset_sat_b got %b want 0", sat_b); end
        n_checks++; if (chan_err_b !== 1'b0)    begin n_fail++; $display("FAIL reset_chan_err_b got %b want 0", chan_err_b); end
        @(negedge clock);
        reset = 1'b0;
        clear_all();
    endtask

    task automatic test_warmup();
        int t1[5] = '{25, 50, 75, 100, 100};
        int lsp, lch, len;
        bit lset, lsat, er, ee;
        do_reset();
        len = 5;
        for (int j = 0; j < len; j++) begin
            sa_v[j] = 1; sa_ch[j] = 0; sa_ph[j] = 100;
            ea_sp[j] = t1[j]; ea_set[j] = (j >= 3);
        end
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            if (k >= 1 && sa_v[k-1] && sa_ch[k-1] >= 3) ee = 1;
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL warmup k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t2[8] = '{-25, 10, -50, 20, -75, 30, -100, 40};
        int lsp, lch, len;
        bit lset, lsat, er, ee;
        do_reset();
        len = 8;
        for (int j = 0; j < len; j++) begin
            sa_v[j] = 1; sa_ch[j] = j % 2; sa_ph[j] = (j % 2) ? 40 : -100;
            ea_sp[j] = t2[j]; ea_set[j] = (j >= 6);
        end
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            if (k >= 1 && sa_v[k-1] && sa_ch[k-1] >= 3) ee = 1;
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL back_to_back k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_flush();
        int lsp, lch, len;
        bit lset, lsat, er, ee;
        do_reset();
        len = 17;
        for (int j = 0; j < 4; j++) begin
            sa_v[j] = 1; sa_ph[j] = 100; ea_sp[j] = 25 * (j + 1); ea_set[j] = (j == 3);
        end
        sa_v[7]  = 1; sa_fl[7] = 1; sa_ph[7] = 80; ea_sp[7] = 20; ea_set[7] = 0;
        for (int j = 8; j < 11; j++) begin
            sa_v[j] = 1; sa_ph[j] = 80; ea_sp[j] = 20 * (j - 6); ea_set[j] = (j == 10);
        end
        sa_fl[14] = 1;
        sa_v[16] = 1; sa_ph[16] = 100; ea_sp[16] = 25; ea_set[16] = 0;
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            if (k >= 1 && sa_v[k-1] && sa_ch[k-1] >= 3) ee = 1;
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL flush k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_chan_err();
        int lsp, lch, len;
        bit lset, lsat, er, ee;
        do_reset();
        len = 3;
        sa_v[0] = 1; sa_ch[0] = 3; sa_ph[0] = 999;
        sa_v[1] = 1; sa_ch[1] = 0; sa_ph[1] = 100; ea_sp[1] = 25; ea_set[1] = 0;
        sa_v[2] = 1; sa_ch[2] = 2; sa_ph[2] = -40; ea_sp[2] = -10; ea_set[2] = 0;
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            if (k >= 1 && sa_v[k-1] && sa_ch[k-1] >= 3) ee = 1;
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL chan_err k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_saturation();
        int lsp, lch, len;
        bit lset, lsat, er;
        do_reset();
        len = 3;
        sb_v[0] = 1; sb_ch[0] = 0; sb_ph[0] = 200000;  eb_sp[0] = 32767;  eb_sat[0] = 1;
        sb_v[1] = 1; sb_ch[1] = 1; sb_ph[1] = -200000; eb_sp[1] = -32768; eb_sat[1] = 1;
        sb_v[2] = 1; sb_ch[2] = 0; sb_ph[2] = 5;       eb_sp[2] = 3750;   eb_sat[2] = 0;
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0;
            if (k >= 3 && sb_v[k-3]) begin
                er = 1; lsp = eb_sp[k-3]; lset = 1; lsat = eb_sat[k-3]; lch = sb_ch[k-3];
            end
            n_checks++;
            if (ob_rdy[k] !== er || ob_err[k] !== 1'b0 || ob_sp[k] !== lsp || ob_set[k] !== lset || ob_sat[k] !== lsat || ob_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL saturation k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=0 speed=%0d set=%0b sat=%0b ch=%0d",
                         k, ob_rdy[k], ob_err[k], ob_sp[k], ob_set[k], ob_sat[k], ob_ch[k], er, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int lsp, lch, len;
        bit lset, lsat, er, ee;
        do_reset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            sample_a = 1; chan_a = 2'd0; phase_a = 19'sd100; flush_a = 0;
        end
        @(negedge clock);
        sample_a = 0;
        n_checks++; if (ready_a !== 1'b1 || speed_a !== 16'sd25) begin n_fail++; $display("FAIL midstream_pre got rdy=%b speed=%0d want rdy=1 speed=25", ready_a, speed_a); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (ready_a !== 1'b0 || speed_a !== 16'sd0 || settled_a !== 1'b0 || speed_chan_a !== 2'd0 || sat_a !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset got rdy=%b speed=%0d set=%b ch=%0d sat=%b want all 0", ready_a, speed_a, settled_a, speed_chan_a, sat_a);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_all();
        len = 1;
        sa_v[0] = 1; sa_ch[0] = 0; sa_ph[0] = 100; ea_sp[0] = 25; ea_set[0] = 0;
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL midstream_after k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
    endtask

    task automatic test_random();
        int lsp, lch, len, sp;
        bit lset, lsat, er, ee, st, sv;
        do_reset();
        len = 56;
        for (int j = 0; j < len; j++) begin
            sa_v[j]  = ($urandom_range(0, 3) != 0);
            sa_ch[j] = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            sa_ph[j] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 524287)) - 262144
                                                   : int'($urandom_range(0, 60000)) - 30000;
            if (sa_v[j] && sa_ch[j] < 3) begin
                model_a(sa_ch[j], sa_ph[j], sp, st, sv);
                ea_sp[j] = sp; ea_set[j] = st; ea_sat[j] = sv;
            end
            sb_v[j]  = ($urandom_range(0, 2) != 0);
            sb_ch[j] = int'($urandom_range(0, 1));
            sb_ph[j] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 524287)) - 262144
                                                   : int'($urandom_range(0, 80)) - 40;
            eb_sp[j] = int'(scale_q(sb_ph[j], 3000, 2, sv));
            eb_sat[j] = sv;
        end
        run_cycles(len);
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0; ee = 0;
            if (k >= 3 && sa_v[k-3] && sa_ch[k-3] < 3) begin
                er = 1; lsp = ea_sp[k-3]; lset = ea_set[k-3]; lsat = ea_sat[k-3]; lch = sa_ch[k-3];
            end
            if (k >= 1 && sa_v[k-1] && sa_ch[k-1] >= 3) ee = 1;
            n_checks++;
            if (oa_rdy[k] !== er || oa_err[k] !== ee || oa_sp[k] !== lsp || oa_set[k] !== lset || oa_sat[k] !== lsat || oa_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL random_a k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d",
                         k, oa_rdy[k], oa_err[k], oa_sp[k], oa_set[k], oa_sat[k], oa_ch[k], er, ee, lsp, lset, lsat, lch);
            end
        end
        lsp = 0; lch = 0; lset = 0; lsat = 0;
        for (int k = 0; k < len + 4; k++) begin
            er = 0;
            if (k >= 3 && sb_v[k-3]) begin
                er = 1; lsp = eb_sp[k-3]; lset = 1; lsat = eb_sat[k-3]; lch = sb_ch[k-3];
            end
            n_checks++;
            if (ob_rdy[k] !== er || ob_err[k] !== 1'b0 || ob_sp[k] !== lsp || ob_set[k] !== lset || ob_sat[k] !== lsat || ob_ch[k] !== lch) begin
                n_fail++;
                $display("FAIL random_b k=%0d got rdy=%0b err=%0b speed=%0d set=%0b sat=%0b ch=%0d want rdy=%0b err=0 speed=%0d set=%0b sat=%0b ch=%0d",
                         k, ob_rdy[k], ob_err[k], ob_sp[k], ob_set[k], ob_sat[k], ob_ch[k], er, lsp, lset, lsat, lch);
            end
        end
    endtask

    initial begin
        clear_all();
        test_reset();
        test_warmup();
        test_back_to_back();
        test_saturation();
        test_flush();
        test_chan_err();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running, want finished");
        $fatal(1);
    end

endmodule
